unified_mem_mp: RTL and testbench

Parametrised multi-port successor to the network's shared weight/activation store. A streaming loader with a valid/ready handshake and an auto-incrementing write pointer fills the array. `NUM_RD` independent registered read ports (one per layer engine) read from it, with per-port valid tracking, a selectable read latency and read-during-write forwarding. It sits between the host/DMA byte stream and the layer datapaths (L1, L2, … Ln).

---
 rtl/unified_mem_mp.sv | 159 +++++++++++++++
 tb/tb_unified_mem_mp.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_mp.sv
// Shared weight/activation store: streaming burst loader with auto-incrementing
// write pointer, NUM_RD independent registered read ports with write forwarding.
module unified_mem_mp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14,
    parameter int NUM_RD = 2,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_start,
    input  logic [ADDR_W-1:0]          wr_base,
    input  logic [ADDR_W:0]            wr_len,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    output logic                       busy,
    output logic                       load_done,
    output logic [ADDR_W:0]            words_written,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     remain_q, remain_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                load_done_q, load_done_d;
    logic                beat;
    logic                data_clean;
    logic                mem_we;

    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remain_q    <= '0;
            words_q     <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remain_q    <= remain_d;
            words_q     <= words_d;
            load_done_q <= load_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remain_d    = remain_q;
        words_d     = words_q;
        load_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_start) begin
                    words_d = '0;
                    if (wr_len != '0) begin
                        ptr_d    = wr_base;
                        remain_d = wr_len;
                        state_d  = LOAD;
                    end else begin
                        load_done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (wr_valid) begin
                    ptr_d    = ptr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    words_d  = words_q + 1'b1;
                    if (remain_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                        state_d     = IDLE;
                        load_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_ready      = (state_q == LOAD);
    assign busy          = (state_q == LOAD);
    assign load_done     = load_done_q;
    assign words_written = words_q;
    assign beat          = (state_q == LOAD) && wr_valid;

    // Beats carrying unknown bits are counted but never reach the array.
`ifdef SYNTHESIS
    assign data_clean = 1'b1;
`else
    assign data_clean = ((^wr_data) !== 1'bx);
`endif

    assign mem_we = beat && data_clean && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q] <= wr_data;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] s1_data_q;
        logic              s1_valid_q;

        assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

        // A read colliding with this cycle's write returns the incoming word.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_data_q  <= '0;
                s1_valid_q <= 1'b0;
            end else begin
                s1_valid_q <= rd_en[gi];
                if (rd_en[gi]) begin
                    s1_data_q <= (mem_we && (ptr_q == addr)) ? wr_data : mem[addr];
                end
            end
        end

        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data_q;
            logic              s2_valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = s2_data_q;
            assign rd_valid[gi]                 = s2_valid_q;
        end else begin : g_lat1
            assign rd_data[gi*DATA_W +: DATA_W] = s1_data_q;
            assign rd_valid[gi]                 = s1_valid_q;
        end
    end

endmodule

// File: tb/tb_unified_mem_mp.sv
// Scoreboard bench: two instances (2 ports/latency 1, 4 ports/latency 2) share
// one write stream; a spec-level model predicts loader outputs and read results.
`timescale 1ns/1ps
module tb_unified_mem_mp;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NA = 2, LA = 1, NB = 4, LB = 2, NP = NA + NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, wr_start, wr_valid;
    logic [ADDR_W-1:0]      wr_base;
    logic [ADDR_W:0]        wr_len;
    logic [DATA_W-1:0]      wr_data;
    logic [NA-1:0]          rd_en_a;
    logic [NA*ADDR_W-1:0]   rd_addr_a;
    logic [NA*DATA_W-1:0]   rd_data_a;
    logic [NA-1:0]          rd_valid_a;
    logic [NB-1:0]          rd_en_b;
    logic [NB*ADDR_W-1:0]   rd_addr_b;
    logic [NB*DATA_W-1:0]   rd_data_b;
    logic [NB-1:0]          rd_valid_b;
    logic                   a_ready, a_busy, a_done, b_ready, b_busy, b_done;
    logic [ADDR_W:0]        a_words, b_words;

    unified_mem_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NA), .RD_LAT(LA)) dut_a (
        .clk(clk), .rst(rst), .wr_start(wr_start), .wr_base(wr_base), .wr_len(wr_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(a_ready), .busy(a_busy),
        .load_done(a_done), .words_written(a_words), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a));

    unified_mem_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NB), .RD_LAT(LB)) dut_b (
        .clk(clk), .rst(rst), .wr_start(wr_start), .wr_base(wr_base), .wr_len(wr_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(b_ready), .busy(b_busy),
        .load_done(b_done), .words_written(b_words), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b));

    // Reference model state
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_known [DEPTH];
    bit                m_load, m_done, started;
    int                m_ptr, m_remain, m_words, cyc;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
        bit                known;
    } exp_t;

    exp_t              q [NP][$];
    logic [DATA_W-1:0] last_d [NP];
    bit                last_k [NP];
    int                checks = 0, errors = 0;

    function automatic int port_lat(int p);
        return (p < NA) ? LA : LB;
    endfunction

    function automatic logic port_en(int p);
        return (p < NA) ? rd_en_a[p] : rd_en_b[p-NA];
    endfunction

    function automatic logic [ADDR_W-1:0] port_addr(int p);
        return (p < NA) ? rd_addr_a[p*ADDR_W +: ADDR_W] : rd_addr_b[(p-NA)*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic port_valid(int p);
        return (p < NA) ? rd_valid_a[p] : rd_valid_b[p-NA];
    endfunction

    function automatic logic [DATA_W-1:0] port_data(int p);
        return (p < NA) ? rd_data_a[p*DATA_W +: DATA_W] : rd_data_b[(p-NA)*DATA_W +: DATA_W];
    endfunction

    function automatic void chk(string name, int p, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (port %0d) cycle %0d: got %0h, expected %0h", name, p, cyc, act, exp);
        end
    endfunction

    // Model: writes of a cycle are applied before that cycle's reads are sampled.
    always @(posedge clk) begin
        bit nd;
        logic [ADDR_W-1:0] a;
        nd = 1'b0;
        cyc++;
        if (rst) begin
            started  = 1'b1;
            m_load   = 1'b0;
            m_done   = 1'b0;
            m_ptr    = 0;
            m_remain = 0;
            m_words  = 0;
            for (int p = 0; p < NP; p++) begin
                q[p].delete();
                last_d[p] = '0;
                last_k[p] = 1'b1;
            end
        end else if (started) begin
            if (m_load) begin
                if (wr_valid) begin
                    m_mem[m_ptr]   = wr_data;
                    m_known[m_ptr] = 1'b1;
                    m_ptr    = (m_ptr + 1) % DEPTH;
                    m_remain = m_remain - 1;
                    m_words  = m_words + 1;
                    if (m_remain == 0) begin
                        m_load = 1'b0;
                        nd     = 1'b1;
                    end
                end
            end else if (wr_start) begin
                m_words = 0;
                if (wr_len != 0) begin
                    m_load   = 1'b1;
                    m_ptr    = int'(wr_base);
                    m_remain = int'(wr_len);
                end else begin
                    nd = 1'b1;
                end
            end
            m_done = nd;
            for (int p = 0; p < NP; p++) begin
                if (port_en(p)) begin
                    a = port_addr(p);
                    q[p].push_back('{due: cyc + port_lat(p) - 1, data: m_mem[a], known: m_known[a]});
                end
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        bit   exp_now;
        exp_t e;
        if (started) begin
            chk("wr_ready_a", 0, 32'(a_ready), 32'(m_load));
            chk("busy_a", 0, 32'(a_busy), 32'(m_load));
            chk("load_done_a", 0, 32'(a_done), 32'(m_done));
            chk("words_written_a", 0, 32'(a_words), 32'(m_words));
            chk("wr_ready_b", 0, 32'(b_ready), 32'(m_load));
            chk("busy_b", 0, 32'(b_busy), 32'(m_load));
            chk("load_done_b", 0, 32'(b_done), 32'(m_done));
            chk("words_written_b", 0, 32'(b_words), 32'(m_words));
            for (int p = 0; p < NP; p++) begin
                exp_now = 1'b0;
                if (q[p].size() > 0) begin
                    e = q[p][0];
                    exp_now = (e.due == cyc);
                end
                chk("rd_valid", p, 32'(port_valid(p)), 32'(exp_now));
                if (exp_now) begin
                    void'(q[p].pop_front());
                    last_d[p] = e.data;
                    last_k[p] = e.known;
                end
                if (last_k[p]) begin
                    chk("rd_data", p, 32'(port_data(p)), 32'(last_d[p]));
                end
            end
        end
    end

    // Stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(int p, logic en, logic [ADDR_W-1:0] addr);
        if (p < NA) begin
            rd_en_a[p] = en;
            rd_addr_a[p*ADDR_W +: ADDR_W] = addr;
        end else begin
            rd_en_b[p-NA] = en;
            rd_addr_b[(p-NA)*ADDR_W +: ADDR_W] = addr;
        end
    endtask

    task automatic clear_reads();
        rd_en_a = '0;
        rd_en_b = '0;
    endtask

    task automatic start_burst(logic [ADDR_W-1:0] base, logic [ADDR_W:0] len);
        wr_start = 1'b1;
        wr_base  = base;
        wr_len   = len;
        tick();
        wr_start = 1'b0;
    endtask

    task automatic send_beat(logic [DATA_W-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic read_all(logic [ADDR_W-1:0] addr);
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, addr);
        tick();
        clear_reads();
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    initial begin
        logic [ADDR_W-1:0] base, ra;
        int guard;
        rst = 1'b1; wr_start = 1'b0; wr_valid = 1'b0;
        wr_base = '0; wr_len = '0; wr_data = '0;
        rd_en_a = '0; rd_en_b = '0; rd_addr_a = '0; rd_addr_b = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic burst
        start_burst(14'h0010, 15'd4);
        send_beat(8'hA1); send_beat(8'hA2); send_beat(8'hA3); send_beat(8'hA4);
        read_all(14'h0012);
        drain();

        // Gaps in wr_valid, wr_start ignored mid-burst
        start_burst(14'h0020, 15'd3);
        send_beat(8'hB1);
        wr_start = 1'b1; wr_base = 14'h0030; wr_len = 15'd5;
        tick();
        wr_start = 1'b0;
        send_beat(8'hB2);
        tick();
        send_beat(8'hB3);
        tick();
        read_all(14'h0020); read_all(14'h0021); read_all(14'h0022); read_all(14'h0030);
        drain();

        // Wrap-around
        start_burst(14'h3FFE, 15'd4);
        send_beat(8'hC1); send_beat(8'hC2); send_beat(8'hC3); send_beat(8'hC4);
        read_all(14'h0000); read_all(14'h3FFF); read_all(14'h0001);
        drain();

        // Read-during-write forwarding on every port
        start_burst(14'h0100, 15'd1);
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, 14'h0100);
        send_beat(8'h5C);
        clear_reads();
        drain();

        // Reset mid-burst
        start_burst(14'h0200, 15'd8);
        send_beat(8'hD1); send_beat(8'hD2); send_beat(8'hD3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        read_all(14'h0200); read_all(14'h0201); read_all(14'h0202);
        start_burst(14'h0208, 15'd2);
        send_beat(8'hE1); send_beat(8'hE2);
        read_all(14'h0209);
        drain();

        // Zero-length burst
        start_burst(14'h0300, 15'd0);
        tick();
        drain();

        // Randomised bursts with concurrent reads
        for (int it = 0; it < 60; it++) begin
            base = ($urandom_range(0, 1) == 1) ? 14'($urandom_range(0, 63))
                                               : 14'($urandom_range(16'h3FF0, 16'h3FFF));
            start_burst(base, 15'($urandom_range(0, 6)));
            guard = 0;
            while (m_load || guard < 3) begin
                wr_valid = ($urandom_range(0, 3) != 0);
                wr_data  = 8'($urandom);
                wr_start = ($urandom_range(0, 7) == 0);
                for (int p = 0; p < NP; p++) begin
                    if ($urandom_range(0, 3) == 0)
                        ra = 14'(m_ptr);
                    else
                        ra = 14'(int'(base) + $urandom_range(0, 9) - 2);
                    set_port(p, 1'($urandom_range(0, 1)), ra);
                end
                tick();
                guard++;
                if (guard > 200) begin
                    errors++;
                    $display("FAIL burst_timeout: loader still busy after %0d cycles, expected idle", guard);
                    break;
                end
            end
            wr_valid = 1'b0;
            wr_start = 1'b0;
            clear_reads();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
